// File: rtl/tns_enc_33_seq_pkg.sv
// Shared TNS definitions: Fibonacci-ordered group weights, word widths, encoder
// state type and the per-group weight lookup used by both encoder and decoder.
package tns_enc_33_seq_pkg;

  localparam int BLEN11 = 24;
  localparam int NGRP   = 11;
  localparam int CODE_W = 3 * NGRP;

  // Each weight is at most one more than the sum of all smaller weights, so
  // greedy MSB-first subtraction reaches every value up to TNS_SUM_ALL.
  localparam logic [BLEN11-1:0] TNS01_C = 24'd1;
  localparam logic [BLEN11-1:0] TNS01_B = 24'd2;
  localparam logic [BLEN11-1:0] TNS01_A = 24'd3;
  localparam logic [BLEN11-1:0] TNS02_C = 24'd5;
  localparam logic [BLEN11-1:0] TNS02_B = 24'd8;
  localparam logic [BLEN11-1:0] TNS02_A = 24'd13;
  localparam logic [BLEN11-1:0] TNS03_C = 24'd21;
  localparam logic [BLEN11-1:0] TNS03_B = 24'd34;
  localparam logic [BLEN11-1:0] TNS03_A = 24'd55;
  localparam logic [BLEN11-1:0] TNS04_C = 24'd89;
  localparam logic [BLEN11-1:0] TNS04_B = 24'd144;
  localparam logic [BLEN11-1:0] TNS04_A = 24'd233;
  localparam logic [BLEN11-1:0] TNS05_C = 24'd377;
  localparam logic [BLEN11-1:0] TNS05_B = 24'd610;
  localparam logic [BLEN11-1:0] TNS05_A = 24'd987;
  localparam logic [BLEN11-1:0] TNS06_C = 24'd1597;
  localparam logic [BLEN11-1:0] TNS06_B = 24'd2584;
  localparam logic [BLEN11-1:0] TNS06_A = 24'd4181;
  localparam logic [BLEN11-1:0] TNS07_C = 24'd6765;
  localparam logic [BLEN11-1:0] TNS07_B = 24'd10946;
  localparam logic [BLEN11-1:0] TNS07_A = 24'd17711;
  localparam logic [BLEN11-1:0] TNS08_C = 24'd28657;
  localparam logic [BLEN11-1:0] TNS08_B = 24'd46368;
  localparam logic [BLEN11-1:0] TNS08_A = 24'd75025;
  localparam logic [BLEN11-1:0] TNS09_C = 24'd121393;
  localparam logic [BLEN11-1:0] TNS09_B = 24'd196418;
  localparam logic [BLEN11-1:0] TNS09_A = 24'd317811;
  localparam logic [BLEN11-1:0] TNS10_C = 24'd514229;
  localparam logic [BLEN11-1:0] TNS10_B = 24'd832040;
  localparam logic [BLEN11-1:0] TNS10_A = 24'd1346269;
  localparam logic [BLEN11-1:0] TNS11_C = 24'd2178309;
  localparam logic [BLEN11-1:0] TNS11_B = 24'd3524578;
  localparam logic [BLEN11-1:0] TNS11_A = 24'd5702887;

  localparam logic [BLEN11-1:0] TNS_SUM_ALL = 24'd14930350;

  typedef enum logic [1:0] {IDLE, RUN, DONE} enc_state_e;

  typedef struct packed {
    logic [BLEN11-1:0] a;
    logic [BLEN11-1:0] b;
    logic [BLEN11-1:0] c;
  } tns_wgt_t;

  function automatic tns_wgt_t tns_weights(input logic [3:0] grp);
    tns_wgt_t w;
    case (grp)
      4'd1:    w = {TNS01_A, TNS01_B, TNS01_C};
      4'd2:    w = {TNS02_A, TNS02_B, TNS02_C};
      4'd3:    w = {TNS03_A, TNS03_B, TNS03_C};
      4'd4:    w = {TNS04_A, TNS04_B, TNS04_C};
      4'd5:    w = {TNS05_A, TNS05_B, TNS05_C};
      4'd6:    w = {TNS06_A, TNS06_B, TNS06_C};
      4'd7:    w = {TNS07_A, TNS07_B, TNS07_C};
      4'd8:    w = {TNS08_A, TNS08_B, TNS08_C};
      4'd9:    w = {TNS09_A, TNS09_B, TNS09_C};
      4'd10:   w = {TNS10_A, TNS10_B, TNS10_C};
      4'd11:   w = {TNS11_A, TNS11_B, TNS11_C};
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/tns_enc_33_seq_if.sv
// Ready/valid bundle between the data source, the TNS encoder and the bus driver.
interface tns_enc_33_seq_if
  import tns_enc_33_seq_pkg::*;
#(
  parameter int DATA_W = BLEN11
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] code_out;
  logic              code_valid;
  logic              code_ready;
  logic              code_err;

  modport master (
    output in_data, in_valid, code_ready,
    input  in_ready, code_out, code_valid, code_err
  );

  modport slave (
    input  in_data, in_valid, code_ready,
    output in_ready, code_out, code_valid, code_err
  );

endinterface

// File: rtl/tns_enc_33_seq_grp_step.sv
// One TNS group: greedy compare-subtract of weights A, B, C in that order.
module tns_grp_step
  import tns_enc_33_seq_pkg::*;
#(
  parameter int DATA_W = BLEN11
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] wA_i,
  input  logic [DATA_W-1:0] wB_i,
  input  logic [DATA_W-1:0] wC_i,
  output logic [2:0]        bits_o,
  output logic [DATA_W-1:0] rem_o
);

  logic [DATA_W-1:0] remAfterA;
  logic [DATA_W-1:0] remAfterB;

  // Each test uses the remainder already reduced by the heavier weights.
  always_comb begin
    bits_o    = 3'b000;
    remAfterA = rem_i;
    remAfterB = '0;
    rem_o     = '0;
    if (rem_i >= wA_i) begin
      bits_o[2] = 1'b1;
      remAfterA = rem_i - wA_i;
    end
    remAfterB = remAfterA;
    if (remAfterA >= wB_i) begin
      bits_o[1] = 1'b1;
      remAfterB = remAfterA - wB_i;
    end
    rem_o = remAfterB;
    if (remAfterB >= wC_i) begin
      bits_o[0] = 1'b1;
      rem_o     = remAfterB - wC_i;
    end
  end

endmodule

// File: rtl/tns_enc_33_seq.sv
// Sequential TNS encoder: one 3-bit group per clock, group 11 first, then the
// finished codeword is held until the downstream handshake.
module tns_enc_33_seq
  import tns_enc_33_seq_pkg::*;
#(
  parameter int DATA_W = BLEN11
) (
  input  logic                   clk,
  input  logic                   rst,
  tns_enc_33_seq_if.slave        bus
);

  enc_state_e        state_q, state_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [3:0]        grp_q, grp_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              err_q, err_d;

  tns_wgt_t          wgt;
  logic [2:0]        stepBits;
  logic [DATA_W-1:0] stepRem;

  assign wgt = tns_weights(grp_q + 4'd1);

  tns_grp_step #(.DATA_W(DATA_W)) u_step (
    .rem_i  (rem_q),
    .wA_i   (DATA_W'(wgt.a)),
    .wB_i   (DATA_W'(wgt.b)),
    .wC_i   (DATA_W'(wgt.c)),
    .bits_o (stepBits),
    .rem_o  (stepRem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      grp_q   <= 4'(NGRP - 1);
      code_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      grp_q   <= grp_d;
      code_q  <= code_d;
      err_q   <= err_d;
    end
  end

  // The error flag reflects whatever remainder survives the group 1 step.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    grp_d   = grp_q;
    code_d  = code_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          rem_d   = bus.in_data;
          code_d  = '0;
          err_d   = 1'b0;
          grp_d   = 4'(NGRP - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        code_d[3*grp_q +: 3] = stepBits;
        rem_d                = stepRem;
        grp_d                = grp_q - 4'd1;
        if (grp_q == 4'd0) begin
          err_d   = (stepRem != '0);
          grp_d   = 4'(NGRP - 1);
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.code_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.code_valid = (state_q == DONE);
  assign bus.code_out   = code_q;
  assign bus.code_err   = err_q;

endmodule

// File: tb/tb_tns_enc_33_seq.sv
// Directed bench for the TNS encoder: a Fibonacci weight model with greedy
// encode/decode, a per-cycle compare process and literal pinned codewords.
module tb_tns_enc_33_seq;
  import tns_enc_33_seq_pkg::*;

  logic clk;
  logic rst;

  tns_enc_33_seq_if #(.DATA_W(BLEN11)) bus ();

  tns_enc_33_seq #(.DATA_W(BLEN11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [23:0] wt [33];
  logic [32:0] expCode;
  logic        expErr;
  logic [23:0] expData;
  logic        expArmed = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Bit b of the codeword carries weight wt[b]; the sequence is Fibonacci.
  function automatic void modelEncode(input logic [23:0] d, output logic [32:0] c, output logic e);
    logic [23:0] r;
    r = d;
    c = '0;
    for (int b = 32; b >= 0; b--) begin
      if (r >= wt[b]) begin
        c[b] = 1'b1;
        r    = r - wt[b];
      end
    end
    e = (r != 24'd0);
  endfunction

  function automatic logic [63:0] decode(input logic [32:0] c);
    logic [63:0] s;
    s = '0;
    for (int b = 0; b < 33; b++) begin
      if (c[b]) s = s + 64'(wt[b]);
    end
    return s;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (expArmed && bus.code_valid) begin
        checkOutput("code_out", bus.code_out, expCode);
        checkOutput("code_err", bus.code_err, expErr);
        if (!expErr) checkOutput("roundtrip", decode(bus.code_out), 64'(expData));
      end else if (!expArmed) begin
        checkOutput("valid_idle", bus.code_valid, 1'b0);
      end
    end
  end

  task automatic waitReady(output logic ok);
    int waitCnt;
    waitCnt = 0;
    @(negedge clk);
    while (!bus.in_ready && waitCnt < 30) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("in_ready_wait", bus.in_ready, 1'b1);
    ok = bus.in_ready;
  endtask

  task automatic acceptWord(input logic [23:0] data);
    bus.in_data  = data;
    bus.in_valid = 1'b1;
    modelEncode(data, expCode, expErr);
    expData = data;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    expArmed     = 1'b1;
  endtask

  task automatic applyStimulus(input logic [23:0] data, input int holdCycles,
                               input logic doLit, input logic [32:0] litCode, input logic litErr);
    logic ok;
    waitReady(ok);
    if (!ok) return;
    acceptWord(data);
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1)  checkOutput("run_in_ready", bus.in_ready, 1'b0);
      if (k == 10) checkOutput("valid_early", bus.code_valid, 1'b0);
    end
    checkOutput("valid_after_e11", bus.code_valid, 1'b1);
    if (doLit) begin
      checkOutput("lit_code", bus.code_out, litCode);
      checkOutput("lit_err", bus.code_err, litErr);
    end
    for (int h = 0; h < holdCycles; h++) begin
      bus.in_valid = (h % 4 == 1);
      bus.in_data  = 24'h5A5A5A;
      @(posedge clk);
      @(negedge clk);
      checkOutput("hold_valid", bus.code_valid, 1'b1);
      checkOutput("hold_in_ready", bus.in_ready, 1'b0);
    end
    bus.in_valid   = 1'b0;
    bus.code_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.code_ready = 1'b0;
    expArmed       = 1'b0;
    @(negedge clk);
    checkOutput("valid_drop", bus.code_valid, 1'b0);
    checkOutput("idle_in_ready", bus.in_ready, 1'b1);
  endtask

  task automatic resetMidRun(input logic [23:0] data);
    logic ok;
    waitReady(ok);
    if (!ok) return;
    acceptWord(data);
    for (int k = 1; k <= 4; k++) @(posedge clk);
    #2;
    rst      = 1'b1;
    expArmed = 1'b0;
    #1;
    checkOutput("rst_in_ready", bus.in_ready, 1'b1);
    checkOutput("rst_valid", bus.code_valid, 1'b0);
    checkOutput("rst_code", bus.code_out, 33'h0);
    checkOutput("rst_err", bus.code_err, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [23:0] rd;
    wt[0] = 24'd1;
    wt[1] = 24'd2;
    for (int i = 2; i < 33; i++) wt[i] = wt[i-1] + wt[i-2];

    rst            = 1'b1;
    bus.in_data    = '0;
    bus.in_valid   = 1'b0;
    bus.code_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_in_ready", bus.in_ready, 1'b1);
    checkOutput("reset_valid", bus.code_valid, 1'b0);
    checkOutput("reset_code", bus.code_out, 33'h0);
    checkOutput("reset_err", bus.code_err, 1'b0);
    rst = 1'b0;

    applyStimulus(24'd0,        0, 1'b1, 33'h0_0000_0000, 1'b0);
    applyStimulus(24'd5702887,  0, 1'b1, 33'h1_0000_0000, 1'b0);
    applyStimulus(24'd1,        0, 1'b1, 33'h0_0000_0001, 1'b0);
    applyStimulus(24'd14930350, 0, 1'b1, 33'h1_FFFF_FFFF, 1'b0);
    applyStimulus(24'd4,        0, 1'b1, 33'h0_0000_0005, 1'b0);
    applyStimulus(24'd14930351, 0, 1'b1, 33'h1_FFFF_FFFF, 1'b1);
    applyStimulus(24'hFFFFFF,   0, 1'b0, 33'h0, 1'b0);
    applyStimulus(24'd1000,    20, 1'b0, 33'h0, 1'b0);

    for (int i = 0; i < 20; i++) applyStimulus(24'(i), 0, 1'b0, 33'h0, 1'b0);
    for (int i = 1; i < 33; i += 5) applyStimulus(wt[i] - 24'd1, 0, 1'b0, 33'h0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      rd = 24'($urandom_range(14930350, 0));
      applyStimulus(rd, 0, 1'b0, 33'h0, 1'b0);
    end

    resetMidRun(24'd123456);
    applyStimulus(TNS06_B, 0, 1'b1, 33'h0_0001_0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
